wb_drain_monitor: RTL

WB_DRAIN_MONITOR -- requirements
Module: wb_drain_monitor

---
 rtl/wb_drain_monitor.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_drain_monitor.sv
// Tracks per-PE reference-particle writebacks and the ring drain that follows them.
// Optional WB_INFLIGHT_CNT_EN: gate drain completion on an in-flight packet counter.
module wb_drain_monitor #(
  parameter int NUM_CELLS    = 64,
  parameter int DRAIN_CYCLES = 64,
  parameter int MAX_INFLIGHT = 256,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CELLS-1:0] ref_wb_issued,
  input  logic                 goto_next_ref,
  input  logic                 clear,
  input  logic [NUM_CELLS-1:0] inject_valid,
  input  logic [NUM_CELLS-1:0] deliver_valid,
  output logic                 all_ref_wb_issued,
  output logic                 interconnect_empty,
  output logic [9:0]           drain_counter,
  output logic [CNT_W-1:0]     inflight_count,
  output logic                 inflight_err
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    EMPTY   = 2'd2
  } state_t;

  localparam logic [9:0] DC_MAX = 10'(DRAIN_CYCLES - 1);

  state_t               state;
  state_t               state_nxt;
  logic [NUM_CELLS-1:0] r_issued;
  logic [NUM_CELLS-1:0] issued_nxt;
  logic [NUM_CELLS-1:0] issued_merged;
  logic [9:0]           drain_nxt;
  logic                 drain_done;

`ifdef WB_INFLIGHT_CNT_EN
  localparam int PC_W  = $clog2(NUM_CELLS + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 2;
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(MAX_INFLIGHT);

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_CELLS-1:0] v);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      n = n + PC_W'(v[i]);
    end
    return n;
  endfunction

  // Returns {range_error, clamped_count}.
  function automatic logic [CNT_W:0] sat_inflight(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1]) begin
      return {1'b1, {CNT_W{1'b0}}};
    end
    if (s > MAX_S) begin
      return {1'b1, CNT_W'(MAX_INFLIGHT)};
    end
    return {1'b0, s[CNT_W-1:0]};
  endfunction

  logic signed [SUM_W-1:0] inflight_sum;
  logic [CNT_W:0]          inflight_sat;

  // Full-width signed sum so a transient negative or overflowing total is visible.
  always_comb begin
    inflight_sum = $signed({{(SUM_W-CNT_W){1'b0}}, inflight_count})
                 + $signed({{(SUM_W-PC_W){1'b0}}, popcount(inject_valid)})
                 - $signed({{(SUM_W-PC_W){1'b0}}, popcount(deliver_valid)});
    inflight_sat = sat_inflight(inflight_sum);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_count <= '0;
      inflight_err   <= 1'b0;
    end else if (clear) begin
      inflight_count <= '0;
      inflight_err   <= 1'b0;
    end else begin
      inflight_count <= inflight_sat[CNT_W-1:0];
      inflight_err   <= inflight_err | inflight_sat[CNT_W];
    end
  end

  assign drain_done = (inflight_count == '0) && !(|inject_valid);
`else
  logic unused_inflight;
  assign unused_inflight    = ^{inject_valid, deliver_valid};
  assign inflight_count     = '0;
  assign inflight_err       = 1'b0;
  assign drain_done         = 1'b1;
`endif

  assign issued_merged = r_issued | ref_wb_issued;

  always_comb begin
    state_nxt  = state;
    issued_nxt = r_issued;
    drain_nxt  = drain_counter;
    if (clear || goto_next_ref) begin
      state_nxt  = COLLECT;
      issued_nxt = '0;
      drain_nxt  = '0;
    end else begin
      unique case (state)
        COLLECT: begin
          issued_nxt = issued_merged;
          if (&issued_merged) begin
            state_nxt = DRAIN;
            drain_nxt = '0;
          end
        end
        DRAIN: begin
          if (drain_counter == DC_MAX) begin
            if (drain_done) state_nxt = EMPTY;
          end else begin
            drain_nxt = drain_counter + 10'd1;
          end
        end
        EMPTY: begin
          state_nxt = EMPTY;
        end
        default: begin
          state_nxt = COLLECT;
          issued_nxt = '0;
          drain_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= COLLECT;
      r_issued      <= '0;
      drain_counter <= '0;
    end else begin
      state         <= state_nxt;
      r_issued      <= issued_nxt;
      drain_counter <= drain_nxt;
    end
  end

  assign all_ref_wb_issued  = (state == DRAIN) || (state == EMPTY);
  assign interconnect_empty = (state == EMPTY);

endmodule
